port_fifo_device: RTL and testbench



---
 rtl/port_fifo_pkg.sv | 32 +++
 rtl/port_fifo_core.sv | 66 ++++++
 rtl/port_fifo_device.sv | 177 +++++++++++++++++
 tb/tb_port_fifo_device.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/port_fifo_pkg.sv
// Shared definitions for the port FIFO peripheral: status byte layout and reset value.
// The optional sticky error flags are enabled with the PORT_FIFO_ERR_FLAGS_EN macro.
package port_fifo_pkg;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_FULL   = 2;
    localparam int ST_RX_EMPTY  = 3;
    localparam int ST_OVERFLOW  = 4;
    localparam int ST_UNDERFLOW = 5;

    localparam int STATUS_W = 8;

    typedef struct packed {
        logic [1:0] reserved;
        logic       underflow;
        logic       overflow;
        logic       rx_empty;
        logic       rx_full;
        logic       tx_empty;
        logic       tx_full;
    } status_t;

    localparam logic [STATUS_W-1:0] RESET_STATUS = 8'h0A;

    // Strobe slots used by the edge detectors in the top module
    localparam int STB_WR   = 0;
    localparam int STB_RD   = 1;
    localparam int STB_STAT = 2;
    localparam int STB_N    = 3;

endpackage

// File: rtl/port_fifo_core.sv
// Synchronous FIFO with combinational head, occupancy counter and wrap-around pointers.
// Push is refused when full and pop when empty, both judged on the state at cycle start.
module port_fifo_core #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

endmodule

// File: rtl/port_fifo_device.sv
// Host-port responder bridging active-low port strobes to TX/RX valid/ready FIFOs.
// Define PORT_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow status flags.
module port_fifo_device
    import port_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             _mr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             _data_oe,
    input  logic             _sel_wr,
    input  logic             _sel_rd,
    input  logic             _stat_rd,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ready,
    input  logic             rx_valid,
    input  logic [WIDTH-1:0] rx_data,
    output logic             rx_ready
);

    logic [STB_N-1:0] strobe_n;
    logic [STB_N-1:0] sel_q_reg;
    logic [STB_N-1:0] fall;
    logic [STB_N-1:STB_RD] armed_reg;
    logic [STB_N-1:STB_RD] armed_next;
    logic [STB_N-1:STB_RD] rise;

    logic             tx_full;
    logic             tx_empty;
    logic             rx_full;
    logic             rx_empty;
    logic [WIDTH-1:0] rx_head;
    logic             host_push;
    logic             host_pop;
    logic             overflow;
    logic             underflow;
    status_t          status;

    assign strobe_n = {_stat_rd, _sel_rd, _sel_wr};

    // sel_q resets low so a strobe already asserted at reset release looks old
    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            sel_q_reg <= '0;
        end else begin
            sel_q_reg <= strobe_n;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STB_N; gi++) begin : g_fall
            assign fall[gi] = ~strobe_n[gi] & sel_q_reg[gi];
        end

        // A read release counts only if its falling edge was seen after reset
        for (gi = STB_RD; gi < STB_N; gi++) begin : g_release
            assign rise[gi] = strobe_n[gi] & ~sel_q_reg[gi] & armed_reg[gi];

            always_comb begin
                armed_next[gi] = armed_reg[gi];
                if (fall[gi]) begin
                    armed_next[gi] = 1'b1;
                end else if (rise[gi]) begin
                    armed_next[gi] = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge _mr) begin
                if (!_mr) begin
                    armed_reg[gi] <= 1'b0;
                end else begin
                    armed_reg[gi] <= armed_next[gi];
                end
            end
        end
    endgenerate

    assign host_push = fall[STB_WR];
    assign host_pop  = rise[STB_RD];

    port_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (_mr),
        .push  (host_push),
        .wdata (data_in),
        .pop   (tx_ready),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    port_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (_mr),
        .push  (rx_valid),
        .wdata (rx_data),
        .pop   (host_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;

`ifdef PORT_FIFO_ERR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;
    logic overflow_set;
    logic underflow_set;
    logic stat_release;

    assign overflow_set  = (host_push & tx_full) | (rx_valid & rx_full);
    assign underflow_set = host_pop & rx_empty;
    assign stat_release  = rise[STB_STAT];

    // A fresh error in the clearing cycle takes priority over the clear
    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (stat_release) begin
                overflow_reg <= 1'b0;
            end
            if (underflow_set) begin
                underflow_reg <= 1'b1;
            end else if (stat_release) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    always_comb begin
        status           = '0;
        status.tx_full   = tx_full;
        status.tx_empty  = tx_empty;
        status.rx_full   = rx_full;
        status.rx_empty  = rx_empty;
        status.overflow  = overflow;
        status.underflow = underflow;
    end

    // Data port has priority; an empty RX presents zero rather than stale storage
    always_comb begin
        data_out = '0;
        _data_oe = 1'b1;
        if (!_sel_rd) begin
            _data_oe = 1'b0;
            data_out = rx_empty ? '0 : rx_head;
        end else if (!_stat_rd) begin
            _data_oe = 1'b0;
            data_out = WIDTH'(status);
        end
    end

endmodule

// File: tb/tb_port_fifo_device.sv
// Self-checking bench for port_fifo_device: table of host/device operations with a status
// expectation each, scoreboards for TX and RX byte order, plus reset and overflow sequences.
module tb_port_fifo_device;
    import port_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
`ifdef PORT_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum {OP_NOP, OP_WRITE, OP_DEVPUSH, OP_READ} op_t;
    typedef struct {
        op_t        op;
        logic [7:0] din;
        logic [7:0] exp_status;
    } vec_t;

    logic             clk = 1'b0;
    logic             mr_n;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             data_oe_n;
    logic             sel_wr_n;
    logic             sel_rd_n;
    logic             stat_rd_n;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             rx_ready;

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    vec_t vecs[12];

    port_fifo_device #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        ._mr      (mr_n),
        .data_in  (data_in),
        .data_out (data_out),
        ._data_oe (data_oe_n),
        ._sel_wr  (sel_wr_n),
        ._sel_rd  (sel_rd_n),
        ._stat_rd (stat_rd_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // TX scoreboard: every accepted head must be the oldest expected byte
    always @(negedge clk) begin
        if (mr_n && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                check("tx_unexpected_accept", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                check("tx_stream", 32'(tx_data), 32'(tx_q[0]));
                void'(tx_q.pop_front());
            end
        end
    end

    task automatic host_write(input logic [7:0] b);
        data_in  = b;
        sel_wr_n = 1'b0;
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
        repeat (2) @(posedge clk);
        #1 sel_wr_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic dev_push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic host_read();
        logic [7:0] want;
        want = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
        sel_rd_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("read_oe", 32'(data_oe_n), 32'd0);
            check("read_data", 32'(data_out), 32'(want));
            @(posedge clk);
            #1;
        end
        sel_rd_n = 1'b1;
        if (rx_q.size() != 0) void'(rx_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic stat_read(output logic [7:0] v);
        stat_rd_n = 1'b0;
        @(negedge clk);
        v = data_out;
        check("stat_oe", 32'(data_oe_n), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 stat_rd_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && tx_q.size() != 0; i++) @(posedge clk);
        #1 tx_ready = 1'b0;
        check({name, "_drained"}, 32'(tx_q.size()), 32'd0);
        @(negedge clk);
        check({name, "_tx_valid_low"}, 32'(tx_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st;

        vecs[0]  = '{OP_NOP,     8'h00, RESET_STATUS};
        vecs[1]  = '{OP_WRITE,   8'h11, 8'h08};
        vecs[2]  = '{OP_WRITE,   8'h22, 8'h08};
        vecs[3]  = '{OP_DEVPUSH, 8'h5A, 8'h00};
        vecs[4]  = '{OP_DEVPUSH, 8'h6B, 8'h00};
        vecs[5]  = '{OP_READ,    8'h00, 8'h00};
        vecs[6]  = '{OP_READ,    8'h00, 8'h08};
        vecs[7]  = '{OP_READ,    8'h00, ERR_EN ? 8'h28 : 8'h08};
        vecs[8]  = '{OP_WRITE,   8'h33, 8'h08};
        vecs[9]  = '{OP_WRITE,   8'h44, 8'h09};
        vecs[10] = '{OP_WRITE,   8'h55, ERR_EN ? 8'h19 : 8'h09};
        vecs[11] = '{OP_NOP,     8'h00, 8'h09};

        mr_n = 1'b0; data_in = '0; sel_wr_n = 1'b1; sel_rd_n = 1'b1; stat_rd_n = 1'b1;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge clk);
        #1 mr_n = 1'b1;
        @(negedge clk);
        check("reset_oe", 32'(data_oe_n), 32'd1);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_tx_valid", 32'(tx_valid), 32'd0);
        check("reset_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            case (vecs[i].op)
                OP_WRITE:   host_write(vecs[i].din);
                OP_DEVPUSH: dev_push(vecs[i].din);
                OP_READ:    host_read();
                default:    ;
            endcase
            stat_read(st);
            $display("vec %0d op %s din %h status %h", i, vecs[i].op.name(), vecs[i].din, st);
            check($sformatf("vec%0d_status", i), 32'(st), 32'(vecs[i].exp_status));
            if (i == 2) check("tx_head_first", 32'(tx_data), 32'h11);
        end
        drain("table");
        stat_read(st);
        check("after_drain_status", 32'(st), 32'(RESET_STATUS));

        // RX overflow: fifth offered byte is refused
        for (int i = 0; i < 5; i++) begin
            dev_push(8'hA0 + 8'(i));
            if (i == 3) begin
                @(negedge clk);
                check("rx_ready_full", 32'(rx_ready), 32'd0);
                @(posedge clk);
                #1;
            end
        end
        stat_read(st);
        $display("rx overflow status %h", st);
        check("rx_full_status", 32'(st), ERR_EN ? 32'h16 : 32'h06);
        check("rx_full_bit", 32'(st[ST_RX_FULL]), 32'd1);
        for (int i = 0; i < 4; i++) host_read();
        stat_read(st);
        check("rx_emptied_status", 32'(st), 32'(RESET_STATUS));

        // Reset asserted in the middle of a write strobe, released with strobe still low
        data_in  = 8'h99;
        sel_wr_n = 1'b0;
        @(posedge clk);
        #3 mr_n = 1'b0;
        #1 check("midreset_tx_valid", 32'(tx_valid), 32'd0);
        @(posedge clk);
        #1 mr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("held_strobe_no_push", 32'(tx_valid), 32'd0);
        sel_wr_n = 1'b1;
        @(posedge clk);
        #1;
        tx_q.delete();
        rx_q.delete();
        stat_read(st);
        $display("post reset status %h", st);
        check("midreset_status", 32'(st), 32'(RESET_STATUS));

        // Next full strobe pushes once; tx_valid rises only after the push edge
        data_in  = 8'h77;
        sel_wr_n = 1'b0;
        tx_q.push_back(8'h77);
        @(negedge clk);
        check("tx_valid_before_edge", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("tx_valid_after_edge", 32'(tx_valid), 32'd1);
        check("tx_data_77", 32'(tx_data), 32'h77);
        @(posedge clk);
        #1 sel_wr_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        drain("post_reset");
        stat_read(st);
        check("final_status", 32'(st), 32'(RESET_STATUS));
        check("final_tx_empty_bit", 32'(st[ST_TX_EMPTY]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
